// File: rtl/bht_update_ctrl_pkg.sv
// Shared types and index helpers for the branch history table write path.
package bht_update_ctrl_pkg;

    localparam int unsigned BHT_INSTR_PER_FETCH = 2;
    localparam int unsigned BHT_VLEN            = 64;
    localparam int unsigned BHT_NR_ENTRIES      = 1024;
    localparam int unsigned BHT_NR_ROWS         = BHT_NR_ENTRIES / BHT_INSTR_PER_FETCH;
    localparam int unsigned BHT_ROW_BITS        = $clog2(BHT_NR_ROWS);
    localparam int unsigned BHT_COL_BITS        = $clog2(BHT_INSTR_PER_FETCH);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } bht_state_e;

    typedef struct packed {
        logic                           valid;
        logic [BHT_ROW_BITS-1:0]        row;
        logic [BHT_INSTR_PER_FETCH-1:0] mask;
        logic                           data;
    } bht_wr_t;

    // Row index: the pc bits just above the column field (pc[0] is never part of an index).
    function automatic logic [BHT_ROW_BITS-1:0] bht_row_idx(input logic [BHT_VLEN-1:0] pc);
        return BHT_ROW_BITS'(pc >> (BHT_COL_BITS + 1));
    endfunction

    function automatic logic [BHT_COL_BITS-1:0] bht_col_idx(input logic [BHT_VLEN-1:0] pc);
        return BHT_COL_BITS'(pc >> 1);
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Small FIFO with synchronous reset/clear and full/empty flags.
module bht_upd_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset; pointers define what is live.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// Sequences BHT valid-array writes: row sweep on reset/flush, queued updates, invalidates.
module bht_update_ctrl
    import bht_update_ctrl_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = BHT_NR_ENTRIES,
    parameter int unsigned INSTR_PER_FETCH = BHT_INSTR_PER_FETCH,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned VLEN            = BHT_VLEN,
    localparam int unsigned NR_ROWS        = NR_ENTRIES / INSTR_PER_FETCH,
    localparam int unsigned ROW_BITS       = $clog2(NR_ROWS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic                       upd_valid_i,
    input  logic [VLEN-1:0]            upd_pc_i,
    output logic                       upd_ready_o,
    input  logic                       inv_valid_i,
    input  logic [VLEN-1:0]            inv_pc_i,
    output logic                       inv_ready_o,
    output logic                       bht_wr_valid_o,
    output logic [ROW_BITS-1:0]        bht_wr_row_o,
    output logic [INSTR_PER_FETCH-1:0] bht_wr_mask_o,
    output logic                       bht_wr_data_o,
    output logic                       pred_enable_o,
    output logic                       flush_done_o
);

    localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
    localparam int unsigned ENT_W    = ROW_BITS + COL_BITS;

    bht_state_e          r_state, w_state_nxt;
    logic [ROW_BITS-1:0] r_cnt, w_cnt_nxt;
    logic                r_rr_inv, w_rr_inv_nxt;

    logic                w_push, w_pop, w_full, w_empty;
    logic [ENT_W-1:0]    w_push_ent, w_head;
    logic [ROW_BITS-1:0] w_upd_row, w_inv_row, w_head_row;
    logic [COL_BITS-1:0] w_upd_col, w_inv_col, w_head_col;

    bht_wr_t             w_wr;
    logic                w_upd_ready, w_inv_ready, w_pred_en, w_flush_done;

    assign w_upd_row  = ROW_BITS'(bht_row_idx(upd_pc_i));
    assign w_upd_col  = COL_BITS'(bht_col_idx(upd_pc_i));
    assign w_inv_row  = ROW_BITS'(bht_row_idx(inv_pc_i));
    assign w_inv_col  = COL_BITS'(bht_col_idx(inv_pc_i));
    assign w_push_ent = {w_upd_row, w_upd_col};
    assign w_head_row = w_head[ENT_W-1:COL_BITS];
    assign w_head_col = w_head[COL_BITS-1:0];

    bht_upd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_clr   (flush_i),
        .i_push  (w_push),
        .i_data  (w_push_ent),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_SWEEP;
            r_cnt    <= '0;
            r_rr_inv <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_inv <= w_rr_inv_nxt;
        end
    end

    // Next state, sweep counter, arbitration and the single table write port.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rr_inv_nxt = r_rr_inv;
        w_wr         = '0;
        w_upd_ready  = 1'b0;
        w_inv_ready  = 1'b0;
        w_pred_en    = 1'b0;
        w_flush_done = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;

        if (!rst_i) begin
            case (r_state)
                ST_SWEEP: begin
                    w_wr.valid = 1'b1;
                    w_wr.row   = r_cnt;
                    w_wr.mask  = '1;
                    w_cnt_nxt  = r_cnt + ROW_BITS'(1);
                    if (r_cnt == ROW_BITS'(NR_ROWS - 1)) begin
                        w_state_nxt  = ST_IDLE;
                        w_flush_done = !flush_i;
                    end
                end
                ST_IDLE: begin
                    w_pred_en   = 1'b1;
                    w_upd_ready = !w_full;
                    w_push      = upd_valid_i && !w_full && !debug_mode_i && !flush_i;
                    if (!flush_i) begin
                        if (inv_valid_i && (w_empty || r_rr_inv)) begin
                            w_inv_ready = 1'b1;
                            w_wr.valid  = 1'b1;
                            w_wr.row    = w_inv_row;
                            w_wr.mask   = INSTR_PER_FETCH'(1) << w_inv_col;
                        end else if (!w_empty) begin
                            w_pop      = 1'b1;
                            w_wr.valid = 1'b1;
                            w_wr.row   = w_head_row;
                            w_wr.mask  = INSTR_PER_FETCH'(1) << w_head_col;
                            w_wr.data  = 1'b1;
                        end
                        if (inv_valid_i && !w_empty) w_rr_inv_nxt = !r_rr_inv;
                    end
                end
                default: w_state_nxt = ST_SWEEP;
            endcase

            if (flush_i) begin
                w_state_nxt = ST_SWEEP;
                w_cnt_nxt   = '0;
            end
        end
    end

    assign bht_wr_valid_o = w_wr.valid;
    assign bht_wr_row_o   = w_wr.row;
    assign bht_wr_mask_o  = w_wr.mask;
    assign bht_wr_data_o  = w_wr.data;
    assign upd_ready_o    = w_upd_ready;
    assign inv_ready_o    = w_inv_ready;
    assign pred_enable_o  = w_pred_en;
    assign flush_done_o   = w_flush_done;

endmodule
